// File: rtl/data_mem.sv
// Single-port 1024 x 32 word-addressed data memory.
// Writes commit on the rising clock edge; reads are combinational and return zero unless a read is enabled.
module data_mem (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  io_addr,
    input  logic [31:0] io_wr_data,
    input  logic [1:0]  io_mem_func,
    input  logic        io_mem_en,
    output logic [31:0] io_rd_data
);

    typedef enum logic [1:0] {
        FUNC_READ  = 2'd0,
        FUNC_WRITE = 2'd1,
        FUNC_NOP_2 = 2'd2,
        FUNC_NOP_3 = 2'd3
    } mem_func_e;

    localparam int unsigned DEPTH = 1024;

    logic [31:0] mem_q [DEPTH];

    logic        wr_req_d;
    logic [9:0]  wr_addr_d;
    logic [31:0] wr_data_d;
    logic        rd_req;

    always_comb begin
        wr_req_d  = io_mem_en && (mem_func_e'(io_mem_func) == FUNC_WRITE);
        wr_addr_d = io_addr;
        wr_data_d = io_wr_data;
    end

    // NOTE: the array has no reset branch on purpose; reset only blocks the write
    // for that cycle, so contents survive it and the array can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (!reset && wr_req_d) begin
            mem_q[wr_addr_d] <= wr_data_d;
        end
    end

    // NOTE: the output gets its zero default before the read branch, so no
    // path leaves io_rd_data unassigned and no latch is inferred.
    always_comb begin
        rd_req     = io_mem_en && (mem_func_e'(io_mem_func) == FUNC_READ);
        io_rd_data = 32'h0;
        if (rd_req) begin
            io_rd_data = mem_q[io_addr];
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed plus randomised bench for data_mem: expected read data is queued when a step
// is driven and popped when the combinational output is sampled mid-cycle.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  io_addr;
    logic [31:0] io_wr_data;
    logic [1:0]  io_mem_func;
    logic        io_mem_en;
    logic [31:0] io_rd_data;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] model [int];

    data_mem dut (
        .clk         (clk),
        .reset       (reset),
        .io_addr     (io_addr),
        .io_wr_data  (io_wr_data),
        .io_mem_func (io_mem_func),
        .io_mem_en   (io_mem_en),
        .io_rd_data  (io_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        logic [31:0] exp;
        string       tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        n_assert++;
        assert (io_rd_data === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, io_rd_data, exp);
        end
    endtask

    // Drive one cycle at the falling edge, sample the output 2ns later, and let
    // the following rising edge commit any write into the reference model.
    task automatic step(input string tag, input logic [9:0] a, input logic [31:0] d,
                        input logic [1:0] f, input logic e, input logic r,
                        input logic [31:0] exp);
        @(negedge clk);
        io_addr     = a;
        io_wr_data  = d;
        io_mem_func = f;
        io_mem_en   = e;
        reset       = r;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #2;
        check_out();
        if (e && f == 2'd1 && !r) model[int'(a)] = d;
    endtask

    // Change only the address inside the current cycle and re-check the output.
    task automatic readdr(input string tag, input logic [9:0] a, input logic [31:0] exp);
        io_addr = a;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        check_out();
    endtask

    initial begin
        logic [9:0]  addrs [16];
        logic [31:0] datas [16];

        reset       = 1'b1;
        io_addr     = '0;
        io_wr_data  = '0;
        io_mem_func = 2'd0;
        io_mem_en   = 1'b0;
        repeat (2) @(posedge clk);

        step("reset_idle_out", 10'd0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0);
        step("reset_write_out", 10'd3, 32'h3, 2'd1, 1'b1, 1'b1, 32'h0);

        step("wr5", 10'd5, 32'hDEADBEEF, 2'd1, 1'b1, 1'b0, 32'h0);
        step("rd5", 10'd5, 32'h0, 2'd0, 1'b1, 1'b0, 32'hDEADBEEF);

        step("wr0", 10'd0, 32'h00000001, 2'd1, 1'b1, 1'b0, 32'h0);
        step("wr1023", 10'd1023, 32'hFFFFFFFF, 2'd1, 1'b1, 1'b0, 32'h0);
        step("rd1023", 10'd1023, 32'h0, 2'd0, 1'b1, 1'b0, 32'hFFFFFFFF);
        step("rd0", 10'd0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h00000001);
        readdr("rd_follow_5", 10'd5, 32'hDEADBEEF);
        readdr("rd_follow_1023", 10'd1023, 32'hFFFFFFFF);
        readdr("rd_follow_0", 10'd0, 32'h00000001);

        step("wr5_disabled", 10'd5, 32'h12345678, 2'd1, 1'b0, 1'b0, 32'h0);
        step("rd5_after_disabled", 10'd5, 32'h0, 2'd0, 1'b1, 1'b0, 32'hDEADBEEF);
        step("rd5_en0", 10'd5, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);

        step("nop2_out", 10'd5, 32'h11111111, 2'd2, 1'b1, 1'b0, 32'h0);
        step("nop3_out", 10'd5, 32'h22222222, 2'd3, 1'b1, 1'b0, 32'h0);
        step("rd5_after_nop", 10'd5, 32'h0, 2'd0, 1'b1, 1'b0, 32'hDEADBEEF);
        step("wr_cycle_out", 10'd5, 32'hCAFEF00D, 2'd1, 1'b1, 1'b0, 32'h0);
        step("rd5_rewritten", 10'd5, 32'h0, 2'd0, 1'b1, 1'b0, 32'hCAFEF00D);

        step("wr7", 10'd7, 32'hA5A5A5A5, 2'd1, 1'b1, 1'b0, 32'h0);
        step("wr7_in_reset", 10'd7, 32'h0, 2'd1, 1'b1, 1'b1, 32'h0);
        step("rd7_in_reset", 10'd7, 32'h0, 2'd0, 1'b1, 1'b1, 32'hA5A5A5A5);
        step("rd7_after_reset", 10'd7, 32'h0, 2'd0, 1'b1, 1'b0, 32'hA5A5A5A5);
        step("rd0_after_reset", 10'd0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h00000001);

        step("wr9_a", 10'd9, 32'h1, 2'd1, 1'b1, 1'b0, 32'h0);
        step("wr9_b", 10'd9, 32'h2, 2'd1, 1'b1, 1'b0, 32'h0);
        step("rd9", 10'd9, 32'h0, 2'd0, 1'b1, 1'b0, 32'h2);

        for (int i = 0; i < 16; i++) begin
            addrs[i] = 10'($urandom_range(1023));
            datas[i] = $urandom;
            step("rand_wr", addrs[i], datas[i], 2'd1, 1'b1, 1'b0, 32'h0);
        end
        for (int i = 15; i >= 0; i--) begin
            step("rand_rd", addrs[i], 32'h0, 2'd0, 1'b1, 1'b0, model[int'(addrs[i])]);
            if (i % 4 == 0) begin
                step("rand_rd_en0", addrs[i], 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
            end
        end
        step("rd5_final", 10'd5, 32'h0, 2'd0, 1'b1, 1'b0, model[5]);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have one clock, clk (input, 1 bit); all state updates occur on its rising edge.
REQ-002 The block SHALL have reset (input, 1 bit), synchronous and active-high, sampled on the rising edge of clk.
REQ-003 io_addr SHALL be an input, 10 bits: word address 0..1023.
REQ-004 io_wr_data SHALL be an input, 32 bits: write data.
REQ-005 io_mem_func SHALL be an input, 2 bits: operation code.
  - 0 = read
  - 1 = write
  - 2 and 3 = no-op
REQ-006 io_mem_en SHALL be an input, 1 bit: access enable, active-high.
REQ-007 io_rd_data SHALL be an output, 32 bits: read data.

Function
REQ-008 Storage SHALL be 1024 words x 32 bits, word-addressed by io_addr; no byte or halfword access.
REQ-009 Write: when io_mem_en=1, io_mem_func=1 and reset=0 at a rising edge, mem[io_addr] SHALL become io_wr_data.
  - New value visible to reads immediately after that edge.
REQ-010 Any other combination at a rising edge SHALL leave all storage unchanged:
  - io_mem_en=0;
  - io_mem_func=0, 2 or 3;
  - reset=1.
REQ-011 Read SHALL be combinational, zero-cycle latency: io_rd_data = mem[io_addr] whenever io_mem_en=1 and io_mem_func=0.
REQ-012 Otherwise io_rd_data SHALL be 32'h0, i.e. when:
  - io_mem_en=0;
  - io_mem_func is 1, 2 or 3.
REQ-013 io_rd_data SHALL follow io_addr changes within the same cycle, with no registering.
REQ-014 Write-then-read of the same address SHALL return the written value from the cycle after the write edge onward.
REQ-015 Back-to-back writes to the same address SHALL leave the last written value.
  - Writes to distinct addresses SHALL not disturb each other.
REQ-016 Addresses 0 and 1023 SHALL be fully usable; there is no wrap-around or out-of-range case, since all 10-bit values are valid.
REQ-017 There SHALL be no handshake or stall; every enabled access completes in one cycle.

Reset
REQ-018 Reset SHALL only suppress writes in cycles where reset=1; it SHALL NOT clear storage contents.
REQ-019 Storage contents after power-up SHALL be undefined.
  - Benches SHALL write a location before checking its read value.
REQ-020 Reset SHALL have no effect on io_rd_data beyond REQ-011 and REQ-012, since the output is purely combinational.
REQ-021 If reset is asserted mid-sequence, previously written words SHALL retain their values through and after reset.

Verification
REQ-022 Basic write/read: write addr 5 = 32'hDEADBEEF, next cycle read addr 5 -> io_rd_data = 32'hDEADBEEF.
REQ-023 Address boundaries:
  - write addr 0 = 32'h00000001 and addr 1023 = 32'hFFFFFFFF;
  - read each -> the matching value;
  - addr 0 still reads 32'h00000001.
REQ-024 Gating:
  - io_mem_en=0, func=1, addr 5, data 32'h12345678 -> addr 5 still reads 32'hDEADBEEF;
  - read with en=0 -> io_rd_data = 32'h0.
REQ-025 No-op and write-cycle output:
  - func=2 or func=3 with en=1 -> no write, io_rd_data = 32'h0;
  - during a func=1 write cycle, io_rd_data = 32'h0.
REQ-026 Reset:
  - write addr 7 = 32'hA5A5A5A5;
  - assert reset=1 while presenting write addr 7 = 32'h0;
  - deassert reset, read addr 7 -> 32'hA5A5A5A5.
REQ-027 Overwrite: write addr 9 = 32'h1, then 32'h2 on the next cycle, then read addr 9 -> 32'h2.
